// File: rtl/router_pkg.sv
// Shared types and helpers for the 16x16 router's per-output-port scheduler.
package router_pkg;

  localparam int N_IN = 16;
  localparam int IDW  = $clog2(N_IN);

  // Output-port scheduler states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAITF = 2'd1,
    XFER  = 2'd2,
    GAP   = 2'd3
  } state_t;

  // Binary input index to one-hot grant vector.
  function automatic logic [N_IN-1:0] onehot(input logic [IDW-1:0] idx);
    logic [N_IN-1:0] r;
    r      = '0;
    r[idx] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/port_out_arbiter_rr_pick.sv
// Rotate-priority encoder: returns the first set request at or after ptr,
// wrapping modulo N_IN.
module rr_pick
  import router_pkg::*;
(
  input  logic [N_IN-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [IDW-1:0]  winner,
  output logic            found
);

  logic [IDW-1:0] idx;

  // Scan ptr, ptr+1, ... and keep the first requester seen.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int k = 0; k < N_IN; k++) begin
      idx = IDW'((int'(ptr) + k) % N_IN);
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/port_out_arbiter.sv
// Per-output-port scheduler: round-robin among requesting inputs, holds the
// grant for a whole packet, then idles GAP_CYC cycles before re-arbitrating.
//
// Handshake: req[i] is a level held by input i while it has a packet for this
// port. grant[i] (registered) is the acknowledge. Once granted, the input
// starts its frame by pulling frame_n_in[i] low; the last bit is the cycle
// with frame_n_in[i]=1 and valid_n_in[i]=0. A grant that never sees
// frame_n_in low within TIMEOUT cycles, or whose req drops before the last
// bit, is revoked with a one-cycle abort pulse.
module port_out_arbiter
  import router_pkg::*;
#(
  parameter int GAP_CYC = 1,
  parameter int TIMEOUT = 64
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [N_IN-1:0] req,
  input  logic [N_IN-1:0] frame_n_in,
  input  logic [N_IN-1:0] valid_n_in,
  output logic [N_IN-1:0] grant,
  output logic [IDW-1:0]  grant_id,
  output logic            port_busy,
  output logic [N_IN-1:0] busy_n,
  output logic            abort,
  output state_t          state_dbg,
  output logic [IDW-1:0]  ptr_dbg
);

  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);
  localparam logic [7:0] GAP_LAST     = 8'(GAP_CYC - 1);
  localparam state_t     EXIT_STATE   = (GAP_CYC == 0) ? IDLE : GAP;

  state_t          state_q, state_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [7:0]      wait_cnt_q, wait_cnt_d;
  logic [7:0]      gap_cnt_q, gap_cnt_d;
  logic [N_IN-1:0] grant_d;
  logic [IDW-1:0]  grant_id_d;
  logic            abort_d;
  logic            port_busy_d;
  logic            kill;

  logic [IDW-1:0]  pick_winner;
  logic            pick_found;

  // Only the granted input's framing signals matter.
  logic g_req, g_frame_n, g_valid_n;
  assign g_req     = req[grant_id];
  assign g_frame_n = frame_n_in[grant_id];
  assign g_valid_n = valid_n_in[grant_id];

  rr_pick u_rr_pick (
    .req    (req),
    .ptr    (ptr_q),
    .winner (pick_winner),
    .found  (pick_found)
  );

  // State, pointer, counters and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      wait_cnt_q <= '0;
      gap_cnt_q  <= '0;
      grant      <= '0;
      grant_id   <= '0;
      port_busy  <= 1'b0;
      abort      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      wait_cnt_q <= wait_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      grant      <= grant_d;
      grant_id   <= grant_id_d;
      port_busy  <= port_busy_d;
      abort      <= abort_d;
    end
  end

  // Next-state decode; kill marks a revoked grant (timeout or req drop).
  always_comb begin
    state_d = state_q;
    kill    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick_found) state_d = WAITF;
      end
      WAITF: begin
        // A falling frame beats a simultaneous timeout or req drop.
        if (!g_frame_n) begin
          state_d = XFER;
        end else if (!g_req || (wait_cnt_q == TIMEOUT_LAST)) begin
          state_d = EXIT_STATE;
          kill    = 1'b1;
        end
      end
      XFER: begin
        // Last bit ends normally even if req drops in the same cycle.
        if (g_frame_n && !g_valid_n) begin
          state_d = EXIT_STATE;
        end else if (!g_frame_n && !g_req) begin
          state_d = EXIT_STATE;
          kill    = 1'b1;
        end
      end
      GAP: begin
        if (gap_cnt_q == GAP_LAST) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Next values for grant, pointer, counters and abort.
  always_comb begin
    grant_d     = grant;
    grant_id_d  = grant_id;
    ptr_d       = ptr_q;
    wait_cnt_d  = wait_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    abort_d     = 1'b0;
    port_busy_d = (state_d != IDLE);
    unique case (state_q)
      IDLE: begin
        if (state_d == WAITF) begin
          grant_d    = onehot(pick_winner);
          grant_id_d = pick_winner;
          ptr_d      = (pick_winner == IDW'(N_IN - 1)) ? '0 : pick_winner + IDW'(1);
          wait_cnt_d = '0;
        end
      end
      WAITF: begin
        if (state_d == WAITF) begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end else if (state_d != XFER) begin
          grant_d    = '0;
          grant_id_d = '0;
          abort_d    = kill;
          gap_cnt_d  = '0;
        end
      end
      XFER: begin
        if (state_d != XFER) begin
          grant_d    = '0;
          grant_id_d = '0;
          abort_d    = kill;
          gap_cnt_d  = '0;
        end
      end
      GAP: begin
        if (state_d == GAP) gap_cnt_d = gap_cnt_q + 8'd1;
      end
      default: begin
        grant_d    = '0;
        grant_id_d = '0;
      end
    endcase
  end

  // A requester is told it is blocked whenever it is not the granted input.
  assign busy_n    = ~(req & ~grant);
  assign state_dbg = state_q;
  assign ptr_dbg   = ptr_q;

endmodule

// File: tb/tb_port_out_arbiter.sv
// Directed bench for port_out_arbiter (GAP_CYC=1, TIMEOUT=64).
module tb_port_out_arbiter;
  import router_pkg::*;

  logic            clock;
  logic            reset;
  logic [N_IN-1:0] req;
  logic [N_IN-1:0] frame_n_in;
  logic [N_IN-1:0] valid_n_in;
  logic [N_IN-1:0] grant;
  logic [IDW-1:0]  grant_id;
  logic            port_busy;
  logic [N_IN-1:0] busy_n;
  logic            abort;
  state_t          state_dbg;
  logic [IDW-1:0]  ptr_dbg;

  int checks   = 0;
  int failures = 0;
  logic [IDW-1:0] exp_q[$];

  port_out_arbiter #(.GAP_CYC(1), .TIMEOUT(64)) dut (
    .clock      (clock),
    .reset      (reset),
    .req        (req),
    .frame_n_in (frame_n_in),
    .valid_n_in (valid_n_in),
    .grant      (grant),
    .grant_id   (grant_id),
    .port_busy  (port_busy),
    .busy_n     (busy_n),
    .abort      (abort),
    .state_dbg  (state_dbg),
    .ptr_dbg    (ptr_dbg)
  );

  // Clock and initial input levels.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // One clock; inputs are driven and outputs sampled 1ns after the edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset();
    reset      = 1'b1;
    req        = '0;
    frame_n_in = '1;
    valid_n_in = '1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Drives nbits data bits on input idx, starting now; last bit has frame_n=1.
  task automatic send_packet(input int idx, input int nbits, input bit drop_req_on_last);
    for (int b = 0; b < nbits - 1; b++) begin
      frame_n_in[idx] = 1'b0;
      valid_n_in[idx] = 1'b0;
      tick();
    end
    frame_n_in[idx] = 1'b1;
    valid_n_in[idx] = 1'b0;
    if (drop_req_on_last) req[idx] = 1'b0;
    tick();
    valid_n_in[idx] = 1'b1;
  endtask

  task automatic test_reset();
    reset      = 1'b1;
    req        = 16'hFFFF;
    frame_n_in = '1;
    valid_n_in = '1;
    tick();
    tick();
    checks++; if (grant !== 16'h0000) begin failures++; $display("FAIL reset_grant got=%h exp=0000", grant); end
    checks++; if (port_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", port_busy); end
    checks++; if (busy_n !== 16'h0000) begin failures++; $display("FAIL reset_busy_n got=%h exp=0000", busy_n); end
    checks++; if (abort !== 1'b0 || grant_id !== 4'd0) begin failures++; $display("FAIL reset_abort_id got=%b/%0d exp=0/0", abort, grant_id); end
    checks++; if (state_dbg !== IDLE || ptr_dbg !== 4'd0) begin failures++; $display("FAIL reset_state got=%0d/%0d exp=0/0", state_dbg, ptr_dbg); end
    reset = 1'b0;
    tick();
    checks++; if (grant !== 16'h0001) begin failures++; $display("FAIL first_grant got=%h exp=0001", grant); end
    checks++; if (port_busy !== 1'b1 || busy_n !== 16'h0001) begin failures++; $display("FAIL first_grant_busy got=%b/%h exp=1/0001", port_busy, busy_n); end
    checks++; if (ptr_dbg !== 4'd1) begin failures++; $display("FAIL first_grant_ptr got=%0d exp=1", ptr_dbg); end
  endtask

  task automatic test_two_inputs();
    logic [IDW-1:0] exp_id;
    apply_reset();
    exp_q.delete();
    exp_q.push_back(4'd0);
    exp_q.push_back(4'd15);
    req = 16'h8001;
    tick();
    exp_id = exp_q.pop_front();
    checks++; if (grant !== 16'h0001 || grant_id !== exp_id) begin failures++; $display("FAIL rr_first got=%h/%0d exp=0001/%0d", grant, grant_id, exp_id); end
    checks++; if (busy_n !== 16'h7FFF) begin failures++; $display("FAIL rr_busy_n got=%h exp=7fff", busy_n); end
    send_packet(0, 8, 1'b1);
    checks++; if (grant !== 16'h0000 || abort !== 1'b0 || state_dbg !== GAP) begin failures++; $display("FAIL rr_end0 got=%h/%b/%0d exp=0000/0/3", grant, abort, state_dbg); end
    checks++; if (port_busy !== 1'b1) begin failures++; $display("FAIL rr_gap_busy got=%b exp=1", port_busy); end
    tick();
    checks++; if (grant !== 16'h0000 || port_busy !== 1'b0 || state_dbg !== IDLE) begin failures++; $display("FAIL rr_idle got=%h/%b/%0d exp=0000/0/0", grant, port_busy, state_dbg); end
    tick();
    exp_id = exp_q.pop_front();
    checks++; if (grant !== 16'h8000 || grant_id !== exp_id) begin failures++; $display("FAIL rr_second got=%h/%0d exp=8000/%0d", grant, grant_id, exp_id); end
    checks++; if (ptr_dbg !== 4'd0) begin failures++; $display("FAIL rr_ptr_wrap got=%0d exp=0", ptr_dbg); end
    send_packet(15, 8, 1'b1);
    checks++; if (grant !== 16'h0000 || abort !== 1'b0) begin failures++; $display("FAIL rr_end15 got=%h/%b exp=0000/0", grant, abort); end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL rr_queue got=%0d exp=0", exp_q.size()); end
  endtask

  task automatic test_timeout();
    apply_reset();
    req = 16'h0020;
    tick();
    checks++; if (grant !== 16'h0020 || ptr_dbg !== 4'd6) begin failures++; $display("FAIL to_grant got=%h/%0d exp=0020/6", grant, ptr_dbg); end
    frame_n_in[4] = 1'b0;   // non-granted input's frame must be ignored
    repeat (63) tick();
    checks++; if (abort !== 1'b0 || state_dbg !== WAITF || grant !== 16'h0020) begin failures++; $display("FAIL to_early got=%b/%0d/%h exp=0/1/0020", abort, state_dbg, grant); end
    tick();
    checks++; if (abort !== 1'b1 || grant !== 16'h0000 || grant_id !== 4'd0) begin failures++; $display("FAIL to_abort got=%b/%h/%0d exp=1/0000/0", abort, grant, grant_id); end
    checks++; if (state_dbg !== GAP || ptr_dbg !== 4'd6) begin failures++; $display("FAIL to_gap got=%0d/%0d exp=3/6", state_dbg, ptr_dbg); end
    frame_n_in[4] = 1'b1;
    tick();
    checks++; if (abort !== 1'b0 || grant !== 16'h0000 || state_dbg !== IDLE) begin failures++; $display("FAIL to_pulse got=%b/%h/%0d exp=0/0000/0", abort, grant, state_dbg); end
    tick();
    checks++; if (grant !== 16'h0020) begin failures++; $display("FAIL to_regrant got=%h exp=0020", grant); end
  endtask

  task automatic test_timeout_frame_wins();
    apply_reset();
    req = 16'h0200;
    tick();
    repeat (63) tick();
    frame_n_in[9] = 1'b0;
    valid_n_in[9] = 1'b0;
    tick();
    checks++; if (state_dbg !== XFER || abort !== 1'b0 || grant !== 16'h0200) begin failures++; $display("FAIL frame_wins got=%0d/%b/%h exp=2/0/0200", state_dbg, abort, grant); end
  endtask

  task automatic test_mid_packet_request();
    apply_reset();
    req = 16'h0008;
    tick();
    frame_n_in[3] = 1'b0;
    valid_n_in[3] = 1'b0;
    tick();
    req = 16'h0088;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++; if (busy_n[7] !== 1'b0 || grant !== 16'h0008) begin failures++; $display("FAIL mid_hold c=%0d got=%b/%h exp=0/0008", c, busy_n[7], grant); end
    end
    frame_n_in[3] = 1'b1;
    req[3] = 1'b0;
    tick();
    valid_n_in[3] = 1'b1;
    checks++; if (grant !== 16'h0000 || busy_n[7] !== 1'b0 || abort !== 1'b0) begin failures++; $display("FAIL mid_end got=%h/%b/%b exp=0000/0/0", grant, busy_n[7], abort); end
    tick();
    tick();
    checks++; if (grant !== 16'h0080 || busy_n[7] !== 1'b1) begin failures++; $display("FAIL mid_next got=%h/%b exp=0080/1", grant, busy_n[7]); end
  endtask

  task automatic test_req_drop_abort();
    apply_reset();
    req = 16'h0004;
    tick();
    frame_n_in[2] = 1'b0;
    valid_n_in[2] = 1'b0;
    tick();
    tick();
    checks++; if (state_dbg !== XFER) begin failures++; $display("FAIL drop_xfer got=%0d exp=2", state_dbg); end
    req[2] = 1'b0;
    tick();
    checks++; if (abort !== 1'b1 || grant !== 16'h0000 || state_dbg !== GAP) begin failures++; $display("FAIL drop_abort got=%b/%h/%0d exp=1/0000/3", abort, grant, state_dbg); end
    frame_n_in[2] = 1'b1;
    valid_n_in[2] = 1'b1;
    tick();
    checks++; if (abort !== 1'b0) begin failures++; $display("FAIL drop_pulse got=%b exp=0", abort); end
  endtask

  task automatic test_reset_mid_xfer();
    apply_reset();
    req = 16'h0002;
    tick();
    frame_n_in[1] = 1'b0;
    valid_n_in[1] = 1'b0;
    tick();
    checks++; if (state_dbg !== XFER || ptr_dbg !== 4'd2) begin failures++; $display("FAIL rst_pre got=%0d/%0d exp=2/2", state_dbg, ptr_dbg); end
    reset = 1'b1;
    tick();
    checks++; if (grant !== 16'h0000 || grant_id !== 4'd0 || port_busy !== 1'b0 || abort !== 1'b0) begin failures++; $display("FAIL rst_mid got=%h/%0d/%b/%b exp=0000/0/0/0", grant, grant_id, port_busy, abort); end
    checks++; if (state_dbg !== IDLE || ptr_dbg !== 4'd0 || busy_n !== 16'hFFFD) begin failures++; $display("FAIL rst_mid_state got=%0d/%0d/%h exp=0/0/fffd", state_dbg, ptr_dbg, busy_n); end
    reset      = 1'b0;
    req        = '0;
    frame_n_in = '1;
    valid_n_in = '1;
  endtask

  // Test sequence and final report.
  initial begin
    reset      = 1'b1;
    req        = '0;
    frame_n_in = '1;
    valid_n_in = '1;
    test_reset();
    test_two_inputs();
    test_timeout();
    test_timeout_frame_wins();
    test_mid_packet_request();
    test_req_drop_abort();
    test_reset_mid_xfer();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
